// File: rtl/sms_trig_pkg.sv
// Shared encodings for the SDTRL trigger pulse driver.
// Optional counters: SMS_TRIG_PULSE_DRIVER_STATS_EN.
package sms_trig_pkg;

    localparam logic [1:0] OP_SET0   = 2'b00;
    localparam logic [1:0] OP_SET1   = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_SAMPLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    typedef enum logic {
        SIDE_LEFT,
        SIDE_RIGHT
    } side_t;

    function automatic logic [1:0] pair_mask(input logic en, input logic pair);
        return en ? (pair ? 2'b10 : 2'b01) : 2'b00;
    endfunction

endpackage

// File: rtl/sms_trig_sync.sv
// Two-flop synchronizer for the asynchronous trigger readback lines.
// Part of the sms_trig_pulse_driver slice (SMS_TRIG_PULSE_DRIVER_STATS_EN unused here).
module sms_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sms_trig_pulse_driver.sv
// Gated AC-set pulse sequencer for SDTRL triggers with readback check.
// Define SMS_TRIG_PULSE_DRIVER_STATS_EN to add stat_ops / stat_errs.
module sms_trig_pulse_driver
    import sms_trig_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_pair,
    output logic [1:0] gate_left,
    output logic [1:0] ac_set_left,
    output logic [1:0] gate_right,
    output logic [1:0] ac_set_right,
    input  logic       trig_b,
    input  logic       trig_p,
    output logic       rsp_valid,
    output logic       rsp_state,
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs,
`endif
    output logic       rsp_err
);

    localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CW-1:0] SETTLE_LD = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic          pair_q;
    side_t         side_q;
    logic          exp_q;
    logic          sync_b;
    logic          sync_p;
    side_t         acc_side;
    logic          acc_exp;
    logic          chk_err;

    sms_trig_sync u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig_b),
        .q     (sync_b)
    );

    sms_trig_sync u_sync_p (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig_p),
        .q     (sync_p)
    );

    // Toggle drives whichever side flips the trigger from its current state.
    always_comb begin
        acc_side = SIDE_LEFT;
        acc_exp  = 1'b0;
        unique case (1'b1)
            (cmd_op == OP_SET1): begin
                acc_side = SIDE_RIGHT;
                acc_exp  = 1'b1;
            end
            (cmd_op == OP_TOGGLE): begin
                acc_side = sync_b ? SIDE_LEFT : SIDE_RIGHT;
                acc_exp  = !sync_b;
            end
            (cmd_op == OP_SAMPLE): acc_exp = sync_b;
            default: ;
        endcase
    end

    assign chk_err = (sync_b == sync_p) ||
                     ((op_q != OP_SAMPLE) && (sync_b != exp_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_q         <= OP_SET0;
            pair_q       <= 1'b0;
            side_q       <= SIDE_LEFT;
            exp_q        <= 1'b0;
            cmd_ready    <= 1'b0;
            gate_left    <= 2'b00;
            ac_set_left  <= 2'b00;
            gate_right   <= 2'b00;
            ac_set_right <= 2'b00;
            rsp_valid    <= 1'b0;
            rsp_state    <= 1'b0;
            rsp_err      <= 1'b0;
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
            stat_ops     <= 16'h0000;
            stat_errs    <= 16'h0000;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        pair_q    <= cmd_pair;
                        side_q    <= acc_side;
                        exp_q     <= acc_exp;
                        if (cmd_op == OP_SAMPLE) begin
                            state <= ST_SETTLE;
                            cnt   <= SETTLE_LD;
                        end else begin
                            state      <= ST_SETUP;
                            cnt        <= SETUP_LD;
                            gate_left  <= pair_mask(acc_side == SIDE_LEFT, cmd_pair);
                            gate_right <= pair_mask(acc_side == SIDE_RIGHT, cmd_pair);
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state        <= ST_PULSE;
                        cnt          <= PULSE_LD;
                        ac_set_left  <= pair_mask(side_q == SIDE_LEFT, pair_q);
                        ac_set_right <= pair_mask(side_q == SIDE_RIGHT, pair_q);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        ac_set_left  <= 2'b00;
                        ac_set_right <= 2'b00;
                        if (HOLD_CYC > 0) begin
                            state <= ST_HOLD;
                            cnt   <= HOLD_LD;
                        end else begin
                            state      <= ST_SETTLE;
                            cnt        <= SETTLE_LD;
                            gate_left  <= 2'b00;
                            gate_right <= 2'b00;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state      <= ST_SETTLE;
                        cnt        <= SETTLE_LD;
                        gate_left  <= 2'b00;
                        gate_right <= 2'b00;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state     <= ST_CHECK;
                        rsp_valid <= 1'b1;
                        rsp_state <= sync_b;
                        rsp_err   <= chk_err;
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
                        if (stat_ops != 16'hFFFF)
                            stat_ops <= stat_ops + 16'd1;
                        if (chk_err && (stat_errs != 16'hFFFF))
                            stat_errs <= stat_errs + 16'd1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sms_trig_pulse_driver.sv
// Randomized self-checking bench for sms_trig_pulse_driver.
// Stats ports are checked when SMS_TRIG_PULSE_DRIVER_STATS_EN is defined.
module tb_sms_trig_pulse_driver;

    localparam int S = 2;
    localparam int P = 3;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_valid2 = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_pair = 1'b0;
    logic       cmd_ready, cmd_ready2;
    logic [1:0] gate_left, ac_set_left, gate_right, ac_set_right;
    logic [1:0] gate_left2, ac_set_left2, gate_right2, ac_set_right2;
    logic       rsp_valid, rsp_state, rsp_err;
    logic       rsp_valid2, rsp_state2, rsp_err2;
    logic       trig_b, trig_p, trig_b2, trig_p2;
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
    logic [15:0] stat_ops, stat_errs, stat_ops2, stat_errs2;
`endif

    logic mb = 1'b1;
    logic mb2 = 1'b1;
    logic stuck = 1'b0;
    logic force_eq = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_ops = 0;
    int   exp_errs = 0;

    always #5 clk = ~clk;

    // Trigger card model: gated AC-set on a side forces its state.
    assign trig_b  = force_eq ? 1'b1 : mb;
    assign trig_p  = force_eq ? 1'b1 : ~mb;
    assign trig_b2 = mb2;
    assign trig_p2 = ~mb2;

    always @(negedge clk) begin
        if (!stuck) begin
            if (|(gate_left & ac_set_left)) mb = 1'b0;
            else if (|(gate_right & ac_set_right)) mb = 1'b1;
        end
        if (|(gate_left2 & ac_set_left2)) mb2 = 1'b0;
        else if (|(gate_right2 & ac_set_right2)) mb2 = 1'b1;
    end

    sms_trig_pulse_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_pair     (cmd_pair),
        .gate_left    (gate_left),
        .ac_set_left  (ac_set_left),
        .gate_right   (gate_right),
        .ac_set_right (ac_set_right),
        .trig_b       (trig_b),
        .trig_p       (trig_p),
        .rsp_valid    (rsp_valid),
        .rsp_state    (rsp_state),
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
        .stat_ops     (stat_ops),
        .stat_errs    (stat_errs),
`endif
        .rsp_err      (rsp_err)
    );

    sms_trig_pulse_driver #(
        .SETUP_CYC (1),
        .PULSE_CYC (3),
        .HOLD_CYC  (0)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid2),
        .cmd_ready    (cmd_ready2),
        .cmd_op       (cmd_op),
        .cmd_pair     (cmd_pair),
        .gate_left    (gate_left2),
        .ac_set_left  (ac_set_left2),
        .gate_right   (gate_right2),
        .ac_set_right (ac_set_right2),
        .trig_b       (trig_b2),
        .trig_p       (trig_p2),
        .rsp_valid    (rsp_valid2),
        .rsp_state    (rsp_state2),
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
        .stat_ops     (stat_ops2),
        .stat_errs    (stat_errs2),
`endif
        .rsp_err      (rsp_err2)
    );

    task automatic settle_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic pair, input bit hold);
        int         lat;
        int         guard;
        logic       b0, tgt, eb, ep, eerr, g, a, len, ren;
        logic [1:0] m;
        logic [9:0] ev, got;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_pair  = pair;
        guard     = 0;
        while (cmd_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++;
            $display("FAIL accept_timeout op=%0d got ready=%b want 1", op, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        b0 = trig_b;
        case (op)
            2'b00:   tgt = 1'b0;
            2'b01:   tgt = 1'b1;
            2'b10:   tgt = !b0;
            default: tgt = b0;
        endcase
        len = (op == 2'b00) || (op == 2'b10 && b0);
        ren = (op == 2'b01) || (op == 2'b10 && !b0);
        m   = pair ? 2'b10 : 2'b01;
        lat = (op == 2'b11) ? 3 : S + P + H + 3;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (hold) cmd_op = 2'($urandom);
                else cmd_valid = 1'b0;
            end
            g   = (op != 2'b11) && (j <= S + P + H);
            a   = (op != 2'b11) && (j > S) && (j <= S + P);
            ev  = {1'b0, j == lat,
                   (len && g) ? m : 2'b00, (len && a) ? m : 2'b00,
                   (ren && g) ? m : 2'b00, (ren && a) ? m : 2'b00};
            got = {cmd_ready, rsp_valid, gate_left, ac_set_left,
                   gate_right, ac_set_right};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL wave op=%0d pair=%0d j=%0d got=%b want=%b",
                         op, pair, j, got, ev);
            end
        end
        eb   = trig_b;
        ep   = trig_p;
        eerr = (eb == ep) || (op != 2'b11 && eb != tgt);
        total++;
        if ({rsp_state, rsp_err} !== {eb, eerr}) begin
            bad++;
            $display("FAIL rsp op=%0d got state/err=%b%b want=%b%b",
                     op, rsp_state, rsp_err, eb, eerr);
        end
        exp_ops++;
        if (eerr) exp_errs++;
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
        total++;
        if (stat_ops !== 16'(exp_ops) || stat_errs !== 16'(exp_errs)) begin
            bad++;
            $display("FAIL stats got ops=%0d errs=%0d want ops=%0d errs=%0d",
                     stat_ops, stat_errs, exp_ops, exp_errs);
        end
`endif
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid, rsp_state, rsp_err, gate_left, ac_set_left,
             gate_right, ac_set_right} !== 12'b0) begin
            bad++;
            $display("FAIL reset_state got ready=%b valid=%b lines=%b%b%b%b want 0",
                     cmd_ready, rsp_valid, gate_left, ac_set_left, gate_right, ac_set_right);
        end
`ifdef SMS_TRIG_PULSE_DRIVER_STATS_EN
        total++;
        if (stat_ops !== 16'd0 || stat_errs !== 16'd0) begin
            bad++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", stat_ops, stat_errs);
        end
`endif
        exp_ops  = 0;
        exp_errs = 0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_set0();
        mb = 1'b1;
        settle_idle();
        run_cmd(2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_set1();
        mb = 1'b0;
        settle_idle();
        run_cmd(2'b01, 1'b1, 1'b0);
        run_cmd(2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_toggle();
        mb = 1'b1;
        settle_idle();
        run_cmd(2'b10, 1'($urandom), 1'b0);
        run_cmd(2'b10, 1'($urandom), 1'b0);
    endtask

    task automatic test_sample_err();
        force_eq = 1'b1;
        settle_idle();
        run_cmd(2'b11, 1'($urandom), 1'b0);
        force_eq = 1'b0;
        settle_idle();
        run_cmd(2'b11, 1'($urandom), 1'b0);
    endtask

    task automatic test_stuck();
        test_reset();
        mb    = 1'b1;
        stuck = 1'b1;
        settle_idle();
        run_cmd(2'b00, 1'b0, 1'b0);
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        mb = 1'b1;
        settle_idle();
        cmd_op    = 2'b00;
        cmd_pair  = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid, gate_left, ac_set_left,
             gate_right, ac_set_right} !== 10'b0) begin
            bad++;
            $display("FAIL reset_mid got ready=%b valid=%b lines=%b%b%b%b want 0",
                     cmd_ready, rsp_valid, gate_left, ac_set_left, gate_right, ac_set_right);
        end
        exp_ops  = 0;
        exp_errs = 0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready got %b want 1", cmd_ready);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_rsp got %0d strobes want 0", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(2) == 0) begin
                mb = 1'($urandom);
                settle_idle();
            end
            run_cmd(2'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++)
            run_cmd(2'($urandom), 1'($urandom), 1'b1);
        cmd_valid = 1'b0;
        settle_idle();
    endtask

    task automatic test_short_build();
        int guard;
        int j;
        mb2 = 1'b1;
        settle_idle();
        cmd_op     = 2'b00;
        cmd_pair   = 1'b1;
        cmd_valid2 = 1'b1;
        guard      = 0;
        while (cmd_ready2 !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        cmd_valid2 = 1'b0;
        j = 1;
        while (rsp_valid2 !== 1'b1 && j < 20) begin
            @(negedge clk);
            j++;
        end
        total++;
        if (j != 7) begin
            bad++;
            $display("FAIL short_latency got %0d want 7", j);
        end
        total++;
        if ({rsp_state2, rsp_err2} !== 2'b00) begin
            bad++;
            $display("FAIL short_rsp got state/err=%b%b want 00", rsp_state2, rsp_err2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_set0();
        test_set1();
        test_toggle();
        test_sample_err();
        test_stuck();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_short_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
